io_trace_capture: RTL and testbench

Synthesisable, parametrised successor to the simulation-only result/IO monitor around the Reduceron core. It captures every IO write (address, data, optional cycle timestamp) into a FIFO drained over a valid/ready port. It tracks GC episodes and latches the final tagged result on `finish`, and it flags a watchdog timeout. It sits beside the `Reduceron` instance, observes its `iowrite`/`ioaddr`/`iowd`, state bit 5 (GC) and `r`/`finish`, and feeds a host-side drain.

---
 rtl/io_trace_capture.sv | 190 +++++++++++++++++++
 tb/tb_io_trace_capture.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/io_trace_capture.sv
// IO write trace capture beside the Reduceron core: FWFT trace FIFO, GC statistics,
// result latch and watchdog. Define IO_TRACE_TIMESTAMP_EN to store per-entry cycle timestamps.
module io_trace_capture #(
    parameter int unsigned ADDR_W  = 15,
    parameter int unsigned DATA_W  = 15,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned RES_W   = 18,
    parameter int unsigned TAG_W   = 3,
    parameter int unsigned TS_W    = 32,
    parameter int unsigned TIMEOUT = 0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   iowrite,
    input  logic [ADDR_W-1:0]      ioaddr,
    input  logic [DATA_W-1:0]      iowd,
    input  logic                   gc,
    input  logic                   finish,
    input  logic [RES_W-1:0]       r,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ADDR_W-1:0]      out_addr,
    output logic [DATA_W-1:0]      out_data,
`ifdef IO_TRACE_TIMESTAMP_EN
    output logic [TS_W-1:0]        out_time,
`endif
    output logic                   overflow,
    output logic [15:0]            drop_count,
    output logic [15:0]            gc_count,
    output logic [TS_W-1:0]        gc_cycles,
    output logic                   done,
    output logic [RES_W-TAG_W-1:0] value,
    output logic                   timeout
);

    localparam int unsigned AW = $clog2(DEPTH);
`ifdef IO_TRACE_TIMESTAMP_EN
    localparam bit          TS_EN = 1'b1;
    localparam int unsigned EW    = ADDR_W + DATA_W + TS_W;
`else
    localparam bit          TS_EN = 1'b0;
    localparam int unsigned EW    = ADDR_W + DATA_W;
`endif
    localparam bit              CNT_EN  = TS_EN || (TIMEOUT != 0);
    localparam logic [TS_W-1:0] WD_LAST = TS_W'(TIMEOUT - 1);

    logic [TS_W-1:0] w_cnt;

    // Free-running cycle counter, only built when a timestamp or watchdog needs it
    generate
        if (CNT_EN) begin : g_cnt
            logic [TS_W-1:0] r_cnt;
            always_ff @(posedge clock) begin
                if (reset) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
            assign w_cnt = r_cnt;
        end else begin : g_no_cnt
            assign w_cnt = '0;
        end
    endgenerate

    logic [EW-1:0] r_mem [DEPTH];
    logic [AW:0]   r_wptr;
    logic [AW:0]   r_rptr;
    logic          w_empty;
    logic          w_full;
    logic          w_wr_req;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic [EW-1:0] w_entry;
    logic [EW-1:0] w_head;

    logic                   r_done;
    logic [RES_W-TAG_W-1:0] r_value;
    logic                   r_timeout;
    logic                   r_overflow;
    logic [15:0]            r_drop;
    logic                   r_gc_q;
    logic [15:0]            r_gc_count;
    logic [TS_W-1:0]        r_gc_cycles;
    logic                   w_wd_hit;
    logic                   w_unused_tag;

    assign w_empty  = (r_wptr == r_rptr);
    assign w_full   = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_wr_req = iowrite && !r_done;
    assign w_pop    = !w_empty && out_ready;
    // A full FIFO still accepts a write when the head leaves in the same cycle
    assign w_push   = w_wr_req && (!w_full || w_pop);
    assign w_drop   = w_wr_req && !w_push;

`ifdef IO_TRACE_TIMESTAMP_EN
    assign w_entry = {ioaddr, iowd, w_cnt};
`else
    assign w_entry = {ioaddr, iowd};
`endif

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= w_entry;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    assign w_head    = w_empty ? '0 : r_mem[r_rptr[AW-1:0]];
    assign out_valid = !w_empty;
    assign out_addr  = w_head[EW-1 -: ADDR_W];
    assign out_data  = w_head[EW-ADDR_W-1 -: DATA_W];
`ifdef IO_TRACE_TIMESTAMP_EN
    assign out_time  = w_head[TS_W-1:0];
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_overflow <= 1'b0;
            r_drop     <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop != 16'hFFFF) begin
                r_drop <= r_drop + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_gc_q      <= 1'b0;
            r_gc_count  <= '0;
            r_gc_cycles <= '0;
        end else begin
            r_gc_q <= gc;
            if (r_gc_q && !gc) begin
                r_gc_count <= r_gc_count + 1'b1;
            end
            if (gc && (r_gc_cycles != '1)) begin
                r_gc_cycles <= r_gc_cycles + 1'b1;
            end
        end
    end

    assign w_unused_tag = ^r[TAG_W-1:0];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_done  <= 1'b0;
            r_value <= '0;
        end else if (finish && !r_done) begin
            r_done  <= 1'b1;
            r_value <= r[RES_W-1:TAG_W];
        end
    end

    // A finish arriving on the expiry cycle takes priority over the watchdog
    assign w_wd_hit = (TIMEOUT != 0) && !r_done && (w_cnt == WD_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_timeout <= 1'b0;
        end else if (w_wd_hit && !finish) begin
            r_timeout <= 1'b1;
        end
    end

    assign overflow   = r_overflow;
    assign drop_count = r_drop;
    assign gc_count   = r_gc_count;
    assign gc_cycles  = r_gc_cycles;
    assign done       = r_done;
    assign value      = r_value;
    assign timeout    = r_timeout;

endmodule

// File: tb/tb_io_trace_capture.sv
// Directed bench for io_trace_capture with a queue scoreboard on the trace output port.
module tb_io_trace_capture;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        iowrite = 1'b0;
    logic [14:0] ioaddr = '0;
    logic [14:0] iowd = '0;
    logic        gc = 1'b0;
    logic        finish = 1'b0;
    logic [17:0] r = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [14:0] out_addr;
    logic [14:0] out_data;
`ifdef IO_TRACE_TIMESTAMP_EN
    logic [31:0] out_time;
`endif
    logic        overflow;
    logic [15:0] drop_count;
    logic [15:0] gc_count;
    logic [31:0] gc_cycles;
    logic        done;
    logic [14:0] value;
    logic        timeout;

    typedef struct {
        logic [14:0] a;
        logic [14:0] d;
        logic [31:0] t;
    } ent_t;

    ent_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    io_trace_capture #(.TIMEOUT(100)) dut (
        .clock(clock), .reset(reset), .iowrite(iowrite), .ioaddr(ioaddr), .iowd(iowd),
        .gc(gc), .finish(finish), .r(r), .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_data(out_data),
`ifdef IO_TRACE_TIMESTAMP_EN
        .out_time(out_time),
`endif
        .overflow(overflow), .drop_count(drop_count), .gc_count(gc_count),
        .gc_cycles(gc_cycles), .done(done), .value(value), .timeout(timeout)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic goto(input int n);
        while (cyc < n) tick();
    endtask

    task automatic wr(input int a, input int d, input bit cap);
        ent_t e;
        iowrite = 1'b1;
        ioaddr  = 15'(a);
        iowd    = 15'(d);
        if (cap) begin
            e.a = 15'(a);
            e.d = 15'(d);
            e.t = 32'(cyc);
            exp_q.push_back(e);
        end
    endtask

    task automatic chk_zero();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_addr", out_addr, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_drop_count", drop_count, 0);
        chk("rst_gc_count", gc_count, 0);
        chk("rst_gc_cycles", gc_cycles, 0);
        chk("rst_done", done, 0);
        chk("rst_value", value, 0);
        chk("rst_timeout", timeout, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1; iowrite = 1'b0; gc = 1'b0; finish = 1'b0; r = '0; out_ready = 1'b0;
        tick();
        tick();
        chk_zero();
        exp_q.delete();
        reset = 1'b0;
        cyc = 0;
    endtask

    // Scoreboard: every accepted head is compared against the oldest expected entry
    always @(negedge clock) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out_addr", {1'b1, out_addr}, {1'b0, out_addr});
            end else begin
                ent_t e;
                e = exp_q.pop_front();
                chk("sb_addr", out_addr, e.a);
                chk("sb_data", out_data, e.d);
`ifdef IO_TRACE_TIMESTAMP_EN
                chk("sb_time", out_time, e.t);
`endif
            end
        end
    end

    initial begin
        // basic stream: writes at cycles 2,3,4 drain back-to-back
        do_reset();
        out_ready = 1'b1;
        goto(2); wr(5, 7, 1);
        tick();  wr(6, 8, 1);
        chk("first_valid", out_valid, 1);
        chk("first_addr", out_addr, 5);
        tick();  wr(7, 9, 1);
        tick();  iowrite = 1'b0;
        tick();
        chk("stream_empty", out_valid, 0);
        chk("stream_q", exp_q.size(), 0);

        // overflow: 20 writes into a 16-deep FIFO with the consumer stalled
        do_reset();
        for (int i = 0; i < 20; i++) begin
            wr(100 + i, 1000 + i, i < 16);
            tick();
        end
        iowrite = 1'b0;
        chk("ovf_flag", overflow, 1);
        chk("ovf_drops", drop_count, 4);
        chk("ovf_head", out_addr, 100);
        wr(200, 2000, 1);
        out_ready = 1'b1;
        tick();
        iowrite = 1'b0; out_ready = 1'b0;
        chk("pushpop_drops", drop_count, 4);
        chk("stall_head", out_addr, 101);
        wr(300, 3000, 0);
        tick();
        iowrite = 1'b0;
        chk("still_full_drops", drop_count, 5);
        chk("stall_head_held", out_addr, 101);
        out_ready = 1'b1;
        repeat (16) tick();
        chk("drain_empty", out_valid, 0);
        chk("drain_q", exp_q.size(), 0);

        // GC statistics and result latch
        do_reset();
        out_ready = 1'b1;
        goto(10); gc = 1'b1;
        goto(15); gc = 1'b0;
        tick();
        chk("gc_count_1", gc_count, 1);
        chk("gc_cycles_5", gc_cycles, 5);
        goto(20); gc = 1'b1;
        goto(22); gc = 1'b0;
        tick();
        chk("gc_count_2", gc_count, 2);
        chk("gc_cycles_7", gc_cycles, 7);
        goto(50);
        chk("done_before", done, 0);
        r = 18'd339; finish = 1'b1; wr(1, 2, 1);
        tick();
        r = '0; finish = 1'b0; wr(3, 4, 0);
        chk("done_set", done, 1);
        chk("value_42", value, 42);
        tick();
        iowrite = 1'b0; finish = 1'b1;
        chk("late_write_ignored", out_valid, 0);
        tick();
        finish = 1'b0;
        chk("value_held", value, 42);
        chk("late_drops", drop_count, 0);
        goto(101);
        chk("no_timeout_after_done", timeout, 0);
        chk("gc_q", exp_q.size(), 0);

        // watchdog expiry at counter 99
        do_reset();
        goto(99);
        chk("wd_before", timeout, 0);
        tick();
        chk("wd_fired", timeout, 1);
        tick();
        chk("wd_sticky", timeout, 1);

        // finish on the expiry cycle wins over the watchdog
        do_reset();
        goto(99);
        r = 18'd40; finish = 1'b1;
        tick();
        finish = 1'b0;
        chk("race_done", done, 1);
        chk("race_timeout", timeout, 0);
        chk("race_value", value, 5);

        // reset in the middle of a busy run
        do_reset();
        for (int i = 0; i < 20; i++) begin
            wr(i, i, 0);
            tick();
        end
        iowrite = 1'b0;
        goto(30); gc = 1'b1;
        goto(34); gc = 1'b0;
        goto(40); r = 18'd16; finish = 1'b1;
        tick(); finish = 1'b0;
        goto(60);
        chk("busy_overflow", overflow, 1);
        chk("busy_done", done, 1);
        reset = 1'b1;
        tick();
        chk_zero();
        reset = 1'b0; cyc = 0; out_ready = 1'b1;
        tick();
        tick();
        chk("post_reset_empty", out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
